// File: rtl/bcd_down_timer.sv
// bcd_down_timer: loadable DIGITS-digit BCD down-counter with
// per-digit borrow, expiry pulse and IDLE/RUN/PAUSED/DONE control.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tick              decrement strobe (honoured only in RUN)
//   load, load_val    preset count (digits >9 clamp to 9), back to IDLE
//   start, pause      begin/resume and suspend counting
//   count             current BCD value, digit 0 in [3:0]
//   bo                pulse when digit 0 wraps 0->9 on a decrement
//   expired           pulse when a decrement lands on zero
//   done, busy        level: in DONE / in RUN or PAUSED
//
// Optional feature macro: BCD_DOWN_TIMER_AUTO_RELOAD_EN
//   When defined, zero is not terminal: the timer stays in RUN and the
//   next honoured tick reloads the last loaded value.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  output logic [4*DIGITS-1:0]   count,
  output logic                  bo,
  output logic                  expired,
  output logic                  done,
  output logic                  busy
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_count;
  logic           r_bo;
  logic           r_exp;
  logic           r_done;
  logic           r_busy;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
  logic [W-1:0]   r_reload;
`endif

  logic [W-1:0]   w_dec;
  logic [W-1:0]   w_clamp;
  logic           w_zero;
  logic           w_one;
  logic           w_bo;

  // Ripple-borrow decrement: a zero digit becomes 9 and passes the
  // borrow up; the first non-zero digit absorbs it.
  always_comb begin
    logic b;
    w_dec   = r_count;
    w_clamp = load_val;
    b       = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        w_clamp[4*i +: 4] = 4'd9;
      if (b) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  end

  assign w_zero = (r_count == '0);
  assign w_one  = (r_count == W'(1));
  assign w_bo   = (r_count[3:0] == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_bo    <= 1'b0;
      r_exp   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_bo  <= 1'b0;
      r_exp <= 1'b0;
      if (load) begin
        r_count <= w_clamp;
        r_state <= S_IDLE;
        r_done  <= 1'b0;
        r_busy  <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        r_reload <= w_clamp;
`endif
      end else begin
        unique case (r_state)
          S_IDLE: begin
            // pause outranks start, and a zero count cannot run
            if (start && !pause && !w_zero) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSED;
            end else if (tick) begin
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
              if (w_zero) begin
                r_count <= r_reload;
              end else if (w_one) begin
                r_count <= '0;
                r_exp   <= 1'b1;
              end else begin
                r_count <= w_dec;
                r_bo    <= w_bo;
              end
`else
              if (w_zero || w_one) begin
                r_count <= '0;
                r_exp   <= !w_zero;
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_count <= w_dec;
                r_bo    <= w_bo;
              end
`endif
            end
          end
          S_PAUSED: begin
            if (start && !pause)
              r_state <= S_RUN;
          end
          S_DONE: begin
            r_state <= S_DONE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = r_count;
  assign bo      = r_bo;
  assign expired = r_exp;
  assign done    = r_done;
  assign busy    = r_busy;

endmodule
